// File: rtl/alt_vipswi130_common_stream_output_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_vipswi130_common_stream_output_if                                |
// | Video stream beat bundle: valid/ready handshake with sop/eop framing |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alt_vipswi130_common_stream_output_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  ready;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (input ready, output valid, output data, output sop, output eop);
  modport slave  (output ready, input valid, input data, input sop, input eop);
endinterface
`default_nettype wire

// File: rtl/alt_vipswi130_common_stream_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_vipswi130_common_stream_output                                   |
// | Switch output stage: packet-boundary enable gating, orphan discard,  |
// | registered Avalon-ST source with ready latency 1.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alt_vipswi130_common_stream_output #(
  parameter int DATA_WIDTH = 10
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  alt_vipswi130_common_stream_output_if.slave  int_s,
  alt_vipswi130_common_stream_output_if.master dout_m,
  input  wire logic                          enable,
  output logic                               synced,
  output logic                               stopped
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PACKET  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  synced_q, synced_d;
  logic                  dout_valid_q;
  logic [DATA_WIDTH-1:0] dout_data_q;
  logic                  dout_sop_q;
  logic                  dout_eop_q;
  logic                  int_ready;
  logic                  xfer;
  logic                  forward;

  // No skid storage: accepting only when downstream is ready this cycle
  // is what makes the registered output honour ready latency 1.
  assign int_ready   = dout_m.ready && (state_q != ST_STOPPED);
  assign xfer        = int_s.valid && int_ready;
  assign int_s.ready = int_ready;

  always_comb begin
    state_d  = state_q;
    synced_d = 1'b0;
    forward  = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (enable) begin
          state_d  = ST_IDLE;
          synced_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (xfer) begin
          // Beats without sop between packets are orphans: consumed, dropped.
          forward = int_s.sop;
          if (int_s.sop && !int_s.eop) begin
            state_d = ST_PACKET;
          end
        end else if (!enable) begin
          state_d  = ST_STOPPED;
          synced_d = 1'b1;
        end
      end
      ST_PACKET: begin
        forward = 1'b1;
        if (xfer && int_s.eop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_STOPPED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOPPED;
      synced_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      synced_q     <= synced_d;
      dout_valid_q <= xfer && forward;
      dout_data_q  <= int_s.data;
      dout_sop_q   <= int_s.sop;
      dout_eop_q   <= int_s.eop;
    end
  end

  assign dout_m.valid = dout_valid_q;
  assign dout_m.data  = dout_data_q;
  assign dout_m.sop   = dout_sop_q;
  assign dout_m.eop   = dout_eop_q;
  assign synced       = synced_q;
  assign stopped      = (state_q == ST_STOPPED);

endmodule
`default_nettype wire

// File: tb/tb_alt_vipswi130_common_stream_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alt_vipswi130_common_stream_output                                |
// | Directed bench for the switch output stage.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alt_vipswi130_common_stream_output;

  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic synced;
  logic stopped;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alt_vipswi130_common_stream_output_if #(.DATA_WIDTH(DW)) int_bus ();
  alt_vipswi130_common_stream_output_if #(.DATA_WIDTH(DW)) dout_bus ();

  alt_vipswi130_common_stream_output #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .int_s   (int_bus),
    .dout_m  (dout_bus),
    .enable  (enable),
    .synced  (synced),
    .stopped (stopped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    int_bus.valid = v;
    int_bus.data  = d;
    int_bus.sop   = s;
    int_bus.eop   = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic s, input logic e);
    check({tag, "_vld"}, 32'(dout_bus.valid), 32'(v));
    if (v) begin
      check({tag, "_data"}, 32'(dout_bus.data), 32'(d));
      check({tag, "_sop"},  32'(dout_bus.sop),  32'(s));
      check({tag, "_eop"},  32'(dout_bus.eop),  32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beat;
    int cyc;
    logic rdy;

    rst = 1'b1;
    enable = 1'b0;
    dout_bus.ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_vld",     32'(dout_bus.valid), 32'd0);
    check("rst_data",    32'(dout_bus.data),  32'd0);
    check("rst_synced",  32'(synced),         32'd0);
    check("rst_stopped", 32'(stopped),        32'd1);
    check("rst_irdy",    32'(int_bus.ready),  32'd0);

    // Enable flow
    rst = 1'b0;
    enable = 1'b1;
    tick();
    check("en_synced",  32'(synced),  32'd1);
    check("en_stopped", 32'(stopped), 32'd0);
    tick();
    check("en_synced_off", 32'(synced), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), i == 1, i == 4);
      #1;
      check("p1_irdy", 32'(int_bus.ready), 32'd1);
      tick();
      check_out("p1", 1'b1, DW'(i), i == 1, i == 4);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check_out("p1_gap", 1'b0, '0, 1'b0, 1'b0);
    check("p1_stopped", 32'(stopped), 32'd0);

    // Backpressure: ready alternates 1,0,1,0...
    beat = 0;
    cyc  = 0;
    while (beat < 6 && cyc < 40) begin
      rdy = (cyc % 2 == 0);
      dout_bus.ready = rdy;
      drive(1'b1, DW'(16 + beat), beat == 0, beat == 5);
      #1;
      check("bp_irdy", 32'(int_bus.ready), 32'(rdy));
      tick();
      check("bp_vld", 32'(dout_bus.valid), 32'(rdy));
      if (rdy) begin
        check("bp_data", 32'(dout_bus.data), 32'(16 + beat));
        beat++;
      end
      cyc++;
    end
    check("bp_beats", 32'(beat), 32'd6);
    dout_bus.ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check_out("bp_gap", 1'b0, '0, 1'b0, 1'b0);

    // Disable mid-packet: enable drops at beat 2 of 5
    for (int i = 1; i <= 5; i++) begin
      if (i >= 2) enable = 1'b0;
      drive(1'b1, DW'(32 + i), i == 1, i == 5);
      tick();
      check_out("dis", 1'b1, DW'(32 + i), i == 1, i == 5);
      check("dis_synced", 32'(synced), 32'd0);
    end
    check("dis_eop_stopped", 32'(stopped), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("dis_stopped", 32'(stopped), 32'd1);
    check("dis_synced_p", 32'(synced), 32'd1);
    check("dis_irdy", 32'(int_bus.ready), 32'd0);
    tick();
    check("dis_synced_off", 32'(synced), 32'd0);

    // Orphan beat in IDLE, then a normal packet
    enable = 1'b1;
    tick();
    check("re_synced", 32'(synced), 32'd1);
    drive(1'b1, 10'h155, 1'b0, 1'b0);
    #1;
    check("orph_irdy", 32'(int_bus.ready), 32'd1);
    tick();
    check("orph_vld", 32'(dout_bus.valid), 32'd0);
    drive(1'b1, 10'h030, 1'b1, 1'b0);
    tick();
    check_out("orph_p0", 1'b1, 10'h030, 1'b1, 1'b0);
    drive(1'b1, 10'h031, 1'b0, 1'b1);
    tick();
    check_out("orph_p1", 1'b1, 10'h031, 1'b0, 1'b1);

    // Single-beat packet with enable drop in the same cycle
    enable = 1'b0;
    drive(1'b1, 10'h03A, 1'b1, 1'b1);
    tick();
    check_out("sb", 1'b1, 10'h03A, 1'b1, 1'b1);
    check("sb_stopped", 32'(stopped), 32'd0);
    check("sb_synced",  32'(synced),  32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("sb_stopped2", 32'(stopped), 32'd1);
    check("sb_synced2",  32'(synced),  32'd1);
    tick();
    check("sb_synced3",  32'(synced),  32'd0);

    // Reset mid-packet at beat 3 of 6
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, DW'(64 + i), i == 1, 1'b0);
      tick();
      check_out("rp", 1'b1, DW'(64 + i), i == 1, 1'b0);
    end
    rst = 1'b1;
    drive(1'b1, DW'(67), 1'b0, 1'b0);
    tick();
    check("rp_vld",     32'(dout_bus.valid), 32'd0);
    check("rp_stopped", 32'(stopped),        32'd1);
    rst = 1'b0;
    drive(1'b1, DW'(68), 1'b0, 1'b0);
    #1;
    check("rp_irdy", 32'(int_bus.ready), 32'd0);
    tick();
    check("rp_synced", 32'(synced), 32'd1);
    for (int i = 4; i <= 6; i++) begin
      drive(1'b1, DW'(64 + i), 1'b0, i == 6);
      tick();
      check("rp_orph_vld", 32'(dout_bus.valid), 32'd0);
    end
    drive(1'b1, 10'h050, 1'b1, 1'b1);
    tick();
    check_out("rp_fresh", 1'b1, 10'h050, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("rp_end_vld", 32'(dout_bus.valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
